// File: rtl/huffman_sched.sv
// huffman_sched: shares one huffman core between NUM_REQ requesters.
// A round-robin arbiter picks a requester and buffers its DATA_SIZE-entry frequency
// table. The table is then burst gaplessly into the core. The core's symbol stream
// is returned to the requester, tagged with the owner's id.
// Optional feature: define HUFF_SCHED_WDOG_EN to enable a WAIT/DRAIN watchdog.
// When the watchdog fires it aborts the job and pulses the core reset.
module huffman_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FREQ_WIDTH = 8,
    parameter int SYM_WIDTH  = 2 * (DATA_WIDTH + 1) + FREQ_WIDTH,
    parameter int WDOG_CYC   = 65535
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_i,
    output logic [NUM_REQ-1:0]                       grant_o,
    input  logic                                     freq_valid_i,
    input  logic [FREQ_WIDTH-1:0]                    freq_data_i,
    output logic                                     freq_ready_o,
    output logic                                     core_start_o,
    output logic                                     core_end_o,
    output logic [FREQ_WIDTH-1:0]                    core_data_o,
    input  logic                                     core_ack_i,
    input  logic [SYM_WIDTH-1:0]                     core_sym_i,
    input  logic                                     core_os_i,
    input  logic                                     core_oe_i,
    output logic                                     core_rst_o,
    output logic                                     res_valid_o,
    output logic [SYM_WIDTH-1:0]                     res_data_o,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] res_id_o,
    output logic                                     res_last_o,
    output logic                                     busy_o,
    output logic                                     err_o
);

    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DATA_SIZE = 1 << DATA_WIDTH;

    if (NUM_REQ < 2 || WDOG_CYC < 2) begin : g_bad_params
        $error("huffman_sched: NUM_REQ and WDOG_CYC must both be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_START,
        S_BURST,
        S_END,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                  state;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         gid;
    logic [ID_W-1:0]         pick_id;
    logic [ID_W-1:0]         next_ptr;
    logic [ID_W:0]           cand;
    logic                    pick_found;
    logic [DATA_WIDTH-1:0]   wcnt;
    logic [DATA_WIDTH-1:0]   rcnt;
    logic                    wr_en;
    logic [FREQ_WIDTH-1:0]   table_mem [DATA_SIZE];

    assign busy_o   = (state != S_IDLE);
    assign wr_en    = (state == S_LOAD) && freq_valid_i && freq_ready_o;
    assign next_ptr = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;

`ifdef HUFF_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic [1:0]        wdog_hold;
    logic              wdog_fire;

    assign wdog_fire  = ((state == S_WAIT) || (state == S_DRAIN)) &&
                        (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
    assign core_rst_o = rst & (wdog_hold == 2'd0);

    // Count cycles spent in WAIT/DRAIN, restarting on entry to each, and stretch the core reset for two cycles after a timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_cnt  <= '0;
            wdog_hold <= 2'd0;
        end else begin
            if (wdog_fire)
                wdog_hold <= 2'd2;
            else if (wdog_hold != 2'd0)
                wdog_hold <= wdog_hold - 2'd1;

            if (((state != S_WAIT) && (state != S_DRAIN)) || wdog_fire ||
                ((state == S_WAIT) && core_os_i))
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign core_rst_o = rst;
`endif

    // Round-robin pick: first requester at or after ptr, wrapping around
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(NUM_REQ))
                cand = cand - (ID_W + 1)'(NUM_REQ);
            if (!pick_found && req_i[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = cand[ID_W-1:0];
            end
        end
    end

    // Table buffer write port; contents need no reset because every job rewrites all entries
    always_ff @(posedge clk) begin
        if (wr_en)
            table_mem[wcnt] <= freq_data_i;
    end

    // Job sequencer: arbitration, table load, core burst and result drain, all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            gid          <= '0;
            grant_o      <= '0;
            freq_ready_o <= 1'b0;
            core_start_o <= 1'b0;
            core_end_o   <= 1'b0;
            core_data_o  <= '0;
            res_valid_o  <= 1'b0;
            res_data_o   <= '0;
            res_id_o     <= '0;
            res_last_o   <= 1'b0;
            err_o        <= 1'b0;
            wcnt         <= '0;
            rcnt         <= '0;
        end else begin
            res_valid_o <= 1'b0;
            res_last_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_i)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (pick_found) begin
                        gid          <= pick_id;
                        grant_o      <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_id;
                        freq_ready_o <= 1'b1;
                        wcnt         <= '0;
                        state        <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (freq_valid_i && freq_ready_o) begin
                        wcnt <= wcnt + 1'b1;
                        if (&wcnt) begin
                            freq_ready_o <= 1'b0;
                            core_start_o <= 1'b1;
                            state        <= S_START;
                        end
                    end
                end
                S_START: begin
                    core_start_o <= 1'b0;
                    core_data_o  <= table_mem[0];
                    rcnt         <= DATA_WIDTH'(1);
                    state        <= S_BURST;
                end
                S_BURST: begin
                    if ((rcnt == DATA_WIDTH'(1)) && !core_ack_i)
                        err_o <= 1'b1;
                    if (rcnt == '0) begin
                        core_data_o <= '0;
                        core_end_o  <= 1'b1;
                        state       <= S_END;
                    end else begin
                        core_data_o <= table_mem[rcnt];
                        rcnt        <= rcnt + 1'b1;
                    end
                end
                S_END: begin
                    core_end_o <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_os_i) begin
                        res_valid_o <= 1'b1;
                        res_data_o  <= core_sym_i;
                        res_id_o    <= gid;
                        res_last_o  <= core_oe_i;
                        if (core_oe_i) begin
                            grant_o <= '0;
                            ptr     <= next_ptr;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    res_valid_o <= 1'b1;
                    res_data_o  <= core_sym_i;
                    res_id_o    <= gid;
                    res_last_o  <= core_oe_i;
                    if (core_oe_i) begin
                        grant_o <= '0;
                        ptr     <= next_ptr;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef HUFF_SCHED_WDOG_EN
            if (wdog_fire) begin
                err_o       <= 1'b1;
                res_valid_o <= 1'b1;
                res_last_o  <= 1'b1;
                res_data_o  <= '0;
                res_id_o    <= gid;
                grant_o     <= '0;
                ptr         <= next_ptr;
                state       <= S_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_huffman_sched.sv
// tb_huffman_sched: scoreboard bench for huffman_sched.
// Stimulus pushes the expected grants, burst words and result words into queues.
// A negedge monitor pops those queues and compares them against the DUT outputs.
// Define HUFF_SCHED_WDOG_EN to also exercise the watchdog timeout.
module tb_huffman_sched;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int FREQ_WIDTH = 8;
    localparam int SYM_WIDTH  = 26;
    localparam int DATA_SIZE  = 256;
    localparam int WDOG_CYC   = 100;

    typedef struct packed {
        logic [SYM_WIDTH-1:0] data;
        logic [1:0]           id;
        logic                 last;
    } res_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  freq_valid_i;
    logic [FREQ_WIDTH-1:0] freq_data_i;
    logic                  freq_ready_o;
    logic                  core_start_o;
    logic                  core_end_o;
    logic [FREQ_WIDTH-1:0] core_data_o;
    logic                  core_ack_i;
    logic [SYM_WIDTH-1:0]  core_sym_i;
    logic                  core_os_i;
    logic                  core_oe_i;
    logic                  core_rst_o;
    logic                  res_valid_o;
    logic [SYM_WIDTH-1:0]  res_data_o;
    logic [1:0]            res_id_o;
    logic                  res_last_o;
    logic                  busy_o;
    logic                  err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FREQ_WIDTH-1:0] exp_burst [$];
    logic [NUM_REQ-1:0]    exp_grant [$];
    res_t                  exp_res   [$];

    int core_id_v   = 0;
    int core_tag    = 0;
    bit core_silent = 1'b0;

    huffman_sched #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .FREQ_WIDTH(FREQ_WIDTH),
        .SYM_WIDTH (SYM_WIDTH),
        .WDOG_CYC  (WDOG_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .freq_valid_i(freq_valid_i),
        .freq_data_i (freq_data_i),
        .freq_ready_o(freq_ready_o),
        .core_start_o(core_start_o),
        .core_end_o  (core_end_o),
        .core_data_o (core_data_o),
        .core_ack_i  (core_ack_i),
        .core_sym_i  (core_sym_i),
        .core_os_i   (core_os_i),
        .core_oe_i   (core_oe_i),
        .core_rst_o  (core_rst_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_id_o    (res_id_o),
        .res_last_o  (res_last_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FREQ_WIDTH-1:0] tableWord(input int seed, input int k);
        return FREQ_WIDTH'(k + seed * 37);
    endfunction

    function automatic logic [SYM_WIDTH-1:0] symFor(input int tag, input int k);
        return SYM_WIDTH'((tag << 18) | (k << 8) | ((k * 3) & 255));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Core model: after core_end_o, emit DATA_SIZE symbols with start/end markers
    initial begin : core_model
        res_t r;
        logic [SYM_WIDTH-1:0] sym;
        core_os_i  = 1'b0;
        core_oe_i  = 1'b0;
        core_sym_i = '0;
        forever begin
            @(negedge clk);
            if (rst && core_end_o && !core_silent) begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < DATA_SIZE; k++) begin
                    sym        = symFor(core_tag, k);
                    core_os_i  = (k == 0);
                    core_oe_i  = (k == DATA_SIZE - 1);
                    core_sym_i = sym;
                    r.data     = sym;
                    r.id       = 2'(core_id_v);
                    r.last     = (k == DATA_SIZE - 1);
                    exp_res.push_back(r);
                    @(negedge clk);
                end
                core_os_i  = 1'b0;
                core_oe_i  = 1'b0;
                core_sym_i = '0;
            end
        end
    end

    // Monitor: compare grants, burst words, end pulse timing and result words
    initial begin : monitor
        int   burst_pos;
        logic prev_ready;
        res_t e;
        burst_pos  = -1;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                burst_pos  = -1;
                prev_ready = 1'b0;
            end else begin
                if (burst_pos >= 0) begin
                    if (burst_pos < DATA_SIZE) begin
                        checkOutput("burst_expected", 32'(exp_burst.size() != 0), 1);
                        if (exp_burst.size() != 0)
                            checkOutput("burst_data", 32'(core_data_o), 32'(exp_burst.pop_front()));
                        checkOutput("burst_no_ctrl", {30'd0, core_start_o, core_end_o}, 0);
                        burst_pos++;
                    end else begin
                        checkOutput("end_pulse", 32'(core_end_o), 1);
                        checkOutput("end_data", 32'(core_data_o), 0);
                        burst_pos = -1;
                    end
                end
                if (core_start_o && burst_pos < 0)
                    burst_pos = 0;
                if (res_valid_o) begin
                    checkOutput("res_expected", 32'(exp_res.size() != 0), 1);
                    if (exp_res.size() != 0) begin
                        e = exp_res.pop_front();
                        checkOutput("res_data", 32'(res_data_o), 32'(e.data));
                        checkOutput("res_id", 32'(res_id_o), 32'(e.id));
                        checkOutput("res_last", 32'(res_last_o), 32'(e.last));
                    end
                end
                if (freq_ready_o && !prev_ready) begin
                    checkOutput("grant_expected", 32'(exp_grant.size() != 0), 1);
                    if (exp_grant.size() != 0)
                        checkOutput("grant", 32'(grant_o), 32'(exp_grant.pop_front()));
                    checkOutput("busy_in_load", 32'(busy_o), 1);
                end
                prev_ready = freq_ready_o;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant_o), 0);
        checkOutput({tag, "_ready"}, 32'(freq_ready_o), 0);
        checkOutput({tag, "_start"}, 32'(core_start_o), 0);
        checkOutput({tag, "_end"}, 32'(core_end_o), 0);
        checkOutput({tag, "_cdata"}, 32'(core_data_o), 0);
        checkOutput({tag, "_core_rst"}, 32'(core_rst_o), 0);
        checkOutput({tag, "_rvalid"}, 32'(res_valid_o), 0);
        checkOutput({tag, "_rdata"}, 32'(res_data_o), 0);
        checkOutput({tag, "_rid"}, 32'(res_id_o), 0);
        checkOutput({tag, "_rlast"}, 32'(res_last_o), 0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 0);
        checkOutput({tag, "_err"}, 32'(err_o), 0);
    endtask

    task automatic feedTable(input int seed, input bit gappy, input bit hold_req);
        int n;
        logic [FREQ_WIDTH-1:0] w;
        n = 0;
        while (!freq_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("grant_wait", 32'(freq_ready_o), 1);
        if (!hold_req)
            req_i = '0;
        for (int k = 0; k < DATA_SIZE; k++) begin
            w = tableWord(seed, k);
            exp_burst.push_back(w);
            freq_valid_i = 1'b1;
            freq_data_i  = w;
            @(negedge clk);
            if (gappy) begin
                freq_valid_i = 1'b0;
                freq_data_i  = 8'hEE;
                @(negedge clk);
            end
        end
        freq_valid_i = 1'b1;
        freq_data_i  = 8'hA5;
        repeat (2) @(negedge clk);
        freq_valid_i = 1'b0;
        freq_data_i  = '0;
    endtask

    task automatic waitDone(input bit exp_err);
        int n;
        n = 0;
        while (busy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("job_done", 32'(busy_o), 0);
        @(negedge clk);
        checkOutput("res_drained", 32'(exp_res.size()), 0);
        checkOutput("burst_drained", 32'(exp_burst.size()), 0);
        checkOutput("err_flag", 32'(err_o), 32'(exp_err));
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] exp_g,
                                 input int exp_id, input int seed, input bit gappy,
                                 input bit ack, input bit hold_req, input bit exp_err);
        exp_grant.push_back(exp_g);
        core_id_v  = exp_id;
        core_tag   = seed + 1;
        core_ack_i = ack;
        req_i      = req;
        feedTable(seed, gappy, hold_req);
        waitDone(exp_err);
        core_ack_i = 1'b1;
    endtask

    initial begin : global_timeout
        #900000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rst          = 1'b0;
        req_i        = '0;
        freq_valid_i = 1'b0;
        freq_data_i  = '0;
        core_ack_i   = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] T2: all requesters, round-robin from pointer 0");
        applyStimulus(4'b1111, 4'b0001, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b0010, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b0100, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b1000, 3, 4, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] T1: single requester 2, table k");
        applyStimulus(4'b0100, 4'b0100, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] T3: gappy load, pointer wraps to requester 0");
        applyStimulus(4'b0001, 4'b0001, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] T4: missing ack sets sticky error");
        applyStimulus(4'b0100, 4'b0100, 2, 6, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 1, 7, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] T5: reset mid-burst");
        exp_grant.push_back(4'b1000);
        core_id_v = 3;
        core_tag  = 9;
        req_i     = 4'b1010;
        feedTable(8, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t5_in_burst", {30'd0, busy_o, core_start_o}, 32'b10);
        rst   = 1'b0;
        req_i = '0;
        @(negedge clk);
        checkResetOutputs("t5_reset");
        rst = 1'b1;
        exp_burst.delete();
        checkOutput("t5_grant_popped", 32'(exp_grant.size()), 0);
        @(negedge clk);
        applyStimulus(4'b1010, 4'b0010, 1, 10, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef HUFF_SCHED_WDOG_EN
        begin : t6
            res_t r;
            int   n;
            $display("[TB] T6: watchdog timeout with silent core");
            core_silent = 1'b1;
            exp_grant.push_back(4'b0100);
            r.data = '0;
            r.id   = 2'd2;
            r.last = 1'b1;
            exp_res.push_back(r);
            req_i = 4'b0100;
            feedTable(11, 1'b0, 1'b0);
            n = 0;
            while (!res_valid_o && n < 400) begin
                @(negedge clk);
                n++;
            end
            checkOutput("t6_fired", 32'(res_valid_o), 1);
            checkOutput("t6_err", 32'(err_o), 1);
            checkOutput("t6_core_rst0", 32'(core_rst_o), 0);
            @(negedge clk);
            checkOutput("t6_core_rst1", 32'(core_rst_o), 0);
            checkOutput("t6_idle", 32'(busy_o), 0);
            @(negedge clk);
            checkOutput("t6_core_rst2", 32'(core_rst_o), 1);
            checkOutput("t6_res_drained", 32'(exp_res.size()), 0);
            core_silent = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
